// File: rtl/fifo_pkg.sv
// Shared constants, state encoding and helpers for the FIFO read-side packer.
package fifo_pkg;

    localparam int PKG_DATA_W = 8;    // FIFO byte width
    localparam int PKG_BYTES  = 4;    // bytes per packed output word
    localparam int PKG_CNT_W  = 16;   // emitted-word counter width
    localparam int PKG_ACC_W  = 3;    // accumulator fill count, holds 0..PKG_BYTES

    // Packer FSM encoding, kept as plain constants for legacy tools
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_RUN        = 2'd0;
    localparam fsm_state_t ST_FLUSH_WAIT = 2'd1;
    localparam fsm_state_t ST_FLUSH_EMIT = 2'd2;

    // Byte-enable mask with the low 'cnt' bytes set: (1 << cnt) - 1
    function automatic logic [PKG_BYTES-1:0] keep_from_cnt(input logic [PKG_ACC_W-1:0] cnt);
        logic [PKG_BYTES:0] w_one_hot;
        w_one_hot     = (PKG_BYTES+1)'(1) << cnt;
        keep_from_cnt = PKG_BYTES'(w_one_hot - (PKG_BYTES+1)'(1));
    endfunction

endpackage

// File: rtl/fifo_out_slot.sv
// Single output register stage of the packer: holds one word on a
// valid/ready stream and keeps it stable while the consumer stalls.
module fifo_out_slot #(
    parameter int DATA_W = 8,
    parameter int BYTES  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_load,
    input  logic [DATA_W*BYTES-1:0] i_data,
    input  logic [BYTES-1:0]        i_keep,
    input  logic                    i_last,
    input  logic                    i_ready,
    output logic [DATA_W*BYTES-1:0] o_data,
    output logic [BYTES-1:0]        o_keep,
    output logic                    o_last,
    output logic                    o_valid,
    output logic                    o_free
);

    // The slot can take a new word when it is empty or being drained now
    assign o_free = !o_valid || i_ready;

    // Load a new word, otherwise drop valid on acceptance and hold contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data  <= '0;
            o_keep  <= '0;
            o_last  <= 1'b0;
            o_valid <= 1'b0;
        end else if (i_load) begin
            o_data  <= i_data;
            o_keep  <= i_keep;
            o_last  <= i_last;
            o_valid <= 1'b1;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end else begin
            o_valid <= o_valid;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side consumer of async_fifo: drains bytes, packs them little-endian
// into words with keep/last flags, and supports a flush of a partial word.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DATA_W = PKG_DATA_W,
    parameter int BYTES  = PKG_BYTES,
    parameter int CNT_W  = PKG_CNT_W
) (
    input  logic                    rdclk,
    input  logic                    aclr_n,
    input  logic                    rdempty,
    output logic                    rdreq,
    input  logic [DATA_W-1:0]       q,
    input  logic                    flush,
    output logic [DATA_W*BYTES-1:0] m_data,
    output logic [BYTES-1:0]        m_keep,
    output logic                    m_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [CNT_W-1:0]        word_cnt
);

    localparam int OUT_W = DATA_W * BYTES;
    localparam int ACC_W = $clog2(BYTES + 1);

    fsm_state_t         r_state;
    fsm_state_t         w_state_nxt;
    logic [OUT_W-1:0]   r_acc;
    logic [OUT_W-1:0]   w_acc_nxt;
    logic [ACC_W-1:0]   r_acc_cnt;
    logic [ACC_W-1:0]   w_acc_cnt_nxt;
    logic [ACC_W-1:0]   w_acc_base;
    logic               r_rd_vld;
    logic               r_run_en;
    logic [CNT_W-1:0]   r_word_cnt;
    logic               w_slot_free;
    logic               w_acc_full;
    logic               w_load;
    logic               w_load_last;
    logic [BYTES-1:0]   w_keep;
    logic [OUT_W-1:0]   w_load_data;
    logic               w_rdreq;

    assign w_acc_full = (r_acc_cnt == ACC_W'(BYTES));

    // FSM: decide when the accumulator is handed to the output slot
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_last = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_load      = w_acc_full && w_slot_free;
                w_state_nxt = flush ? ST_FLUSH_WAIT : ST_RUN;
            end
            ST_FLUSH_WAIT: begin
                if (r_rd_vld) begin
                    w_state_nxt = ST_FLUSH_WAIT;          // absorb the in-flight byte first
                end else if (r_acc_cnt == ACC_W'(0)) begin
                    w_state_nxt = ST_RUN;                 // nothing to flush
                end else if (w_acc_full) begin
                    w_load      = w_slot_free;
                    w_load_last = w_slot_free;
                    w_state_nxt = w_slot_free ? ST_RUN : ST_FLUSH_WAIT;
                end else begin
                    w_state_nxt = ST_FLUSH_EMIT;
                end
            end
            ST_FLUSH_EMIT: begin
                w_load      = w_slot_free;
                w_load_last = w_slot_free;
                w_state_nxt = w_slot_free ? ST_RUN : ST_FLUSH_EMIT;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Datapath: landing byte slot, outgoing word masking, and read request.
    // Space is counted after this cycle's hand-off so that a fresh read can
    // start in the transfer cycle, giving one word every five cycles.
    always_comb begin
        w_acc_base    = w_load ? ACC_W'(0) : r_acc_cnt;
        w_acc_cnt_nxt = w_acc_base + ACC_W'(r_rd_vld);
        w_keep        = keep_from_cnt(r_acc_cnt);
        w_acc_nxt     = r_acc;
        w_load_data   = '0;
        for (int i = 0; i < BYTES; i++) begin
            w_acc_nxt[i*DATA_W +: DATA_W] = (r_rd_vld && (w_acc_base == ACC_W'(i)))
                                            ? q : r_acc[i*DATA_W +: DATA_W];
            w_load_data[i*DATA_W +: DATA_W] = w_keep[i] ? r_acc[i*DATA_W +: DATA_W]
                                                        : DATA_W'(0);
        end
        w_rdreq = r_run_en && !rdempty && (r_state == ST_RUN) &&
                  (((ACC_W+1)'(w_acc_base) + (ACC_W+1)'(r_rd_vld)) < (ACC_W+1)'(BYTES));
    end

    assign rdreq    = w_rdreq;
    assign word_cnt = r_word_cnt;

    // Accumulator, FSM state and read pipeline; r_run_en keeps rdreq low
    // until the first clock edge after reset release
    always_ff @(posedge rdclk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_state   <= ST_RUN;
            r_acc     <= '0;
            r_acc_cnt <= '0;
            r_rd_vld  <= 1'b0;
            r_run_en  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_acc_cnt <= w_acc_cnt_nxt;
            r_rd_vld  <= w_rdreq;
            r_run_en  <= 1'b1;
        end
    end

    // Count accepted words, wrapping naturally at the counter width
    always_ff @(posedge rdclk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_word_cnt <= '0;
        end else if (m_valid && m_ready) begin
            r_word_cnt <= r_word_cnt + CNT_W'(1);
        end else begin
            r_word_cnt <= r_word_cnt;
        end
    end

    fifo_out_slot #(
        .DATA_W (DATA_W),
        .BYTES  (BYTES)
    ) u_out_slot (
        .clk     (rdclk),
        .rst_n   (aclr_n),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_keep  (w_keep),
        .i_last  (w_load_last),
        .i_ready (m_ready),
        .o_data  (m_data),
        .o_keep  (m_keep),
        .o_last  (m_last),
        .o_valid (m_valid),
        .o_free  (w_slot_free)
    );

endmodule
